// File: rtl/rr_arb_mux_if.sv
// Valid/ready bundle between NCH producer channels, the arbitrating mux and its consumer.
// RR_ARB_MUX_PKT_LOCK_EN adds the in_last/out_last packet-boundary signals.
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8
);
  localparam int SEL_W = $clog2(NCH);

  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       chan_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_sel;

  // master is the mux itself; slave is the producer/consumer environment around it
`ifdef RR_ARB_MUX_PKT_LOCK_EN
  logic [NCH-1:0]       in_last;
  logic                 out_last;

  modport master (
    input  in_valid, in_data, chan_en, out_ready, in_last,
    output in_ready, out_valid, out_data, out_sel, out_last
  );
  modport slave (
    output in_valid, in_data, chan_en, out_ready, in_last,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );
`else
  modport master (
    input  in_valid, in_data, chan_en, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
  modport slave (
    output in_valid, in_data, chan_en, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
`endif
endinterface

// File: rtl/rr_arb_mux.sv
// Registered NCH-to-1 round-robin arbitrating mux; the granted index travels with the data.
// Define RR_ARB_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last word.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8
) (
  input  logic         clk,
  input  logic         reset,
  rr_arb_mux_if.master bus
);
  localparam int SEL_W = $clog2(NCH);

  logic [NCH-1:0]   req;
  logic             loadEn;
  logic             rrFound;
  logic [SEL_W-1:0] rrIdx;
  logic             found;
  logic [SEL_W-1:0] grantIdx;
  logic [NCH-1:0]   grantOh;
  logic             xfer;
  int               cand;

  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [SEL_W-1:0] outSel_q, outSel_d;
  logic [SEL_W-1:0] lastGrant_q, lastGrant_d;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
  logic             outLast_q, outLast_d;
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lockCh_q, lockCh_d;
`endif

  assign req    = bus.in_valid & bus.chan_en;
  assign loadEn = !outValid_q || bus.out_ready;

  // First requester strictly after lastGrant_q, wrapping past NCH-1 back to 0
  always_comb begin
    rrFound = 1'b0;
    rrIdx   = '0;
    cand    = 0;
    for (int i = 1; i <= NCH; i++) begin
      cand = int'(lastGrant_q) + i;
      if (cand >= NCH) cand = cand - NCH;
      if (!rrFound && req[cand]) begin
        rrFound = 1'b1;
        rrIdx   = cand[SEL_W-1:0];
      end
    end
  end

`ifdef RR_ARB_MUX_PKT_LOCK_EN
  assign found    = lock_q ? req[lockCh_q] : rrFound;
  assign grantIdx = lock_q ? lockCh_q : rrIdx;
`else
  assign found    = rrFound;
  assign grantIdx = rrIdx;
`endif

  assign xfer = found && loadEn && !reset;

  always_comb begin
    grantOh = '0;
    if (xfer) grantOh[grantIdx] = 1'b1;
  end

  assign bus.in_ready  = grantOh;
  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_sel   = outSel_q;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
  assign bus.out_last  = outLast_q;
`endif

  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outSel_d    = outSel_q;
    lastGrant_d = lastGrant_q;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    outLast_d   = outLast_q;
    lock_d      = lock_q;
    lockCh_d    = lockCh_q;
`endif
    if (xfer) begin
      outValid_d = 1'b1;
      outData_d  = bus.in_data[int'(grantIdx)*WIDTH +: WIDTH];
      outSel_d   = grantIdx;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      // Mid-packet words keep the pointer still so the rotation resumes after the packet
      outLast_d = bus.in_last[grantIdx];
      lock_d    = !bus.in_last[grantIdx];
      lockCh_d  = grantIdx;
      if (bus.in_last[grantIdx]) lastGrant_d = grantIdx;
`else
      lastGrant_d = grantIdx;
`endif
    end else if (bus.out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outSel_q    <= '0;
      lastGrant_q <= SEL_W'(NCH - 1);
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      outLast_q   <= 1'b0;
      lock_q      <= 1'b0;
      lockCh_q    <= '0;
`endif
    end else begin
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outSel_q    <= outSel_d;
      lastGrant_q <= lastGrant_d;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      outLast_q   <= outLast_d;
      lock_q      <= lock_d;
      lockCh_q    <= lockCh_d;
`endif
    end
  end
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised, registered N-to-1 arbitrating multiplexer for the FIFO subsystem; next generation of the fixed 8-to-1 select mux.
- Merges NCH valid/ready input channels onto one registered valid/ready output stream.
- Selection is made by an internal round-robin arbiter, not by an external select; the granted channel index travels with the data.
- Typical use: several producer FIFOs drain into one consumer FIFO.

Parameters:
WIDTH, 32, data width of each channel and of the output
NCH, 8, number of input channels, 2..32
SEL_W, $clog2(NCH), width of the channel index; derived, must not be overridden

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  NCH  per-channel data valid
in_ready  output  NCH  per-channel ready; at most one bit high
in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
chan_en  input  NCH  per-channel arbitration enable; 0 masks the channel out
out_valid  output  1  output register holds valid data
out_ready  input  1  downstream accepts data
out_data  output  WIDTH  registered data
out_sel  output  SEL_W  index of the channel that supplied out_data

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset, sampled on the clk edge:
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer last_grant=NCH-1, so channel 0 has first priority.
  - While reset=1, in_ready=0 regardless of other inputs.
- load_en = !out_valid || out_ready. This is combinational; in_ready may depend combinationally on out_ready.
- Request vector: req = in_valid & chan_en.
- Grant:
  - When load_en=1 and req!=0, grant = first set bit of req, searching upward from (last_grant+1) mod NCH and wrapping past NCH-1 to 0.
  - in_ready = onehot(grant) when load_en=1 and req!=0; otherwise in_ready=0.
  - in_ready never goes high for a masked or non-requesting channel.
- Transfer: channel k transfers when in_valid[k] && in_ready[k]. On that edge:
  - out_data <= in_data[k].
  - out_sel <= k.
  - out_valid <= 1.
  - last_grant <= k.
- No transfer and out_ready=1: out_valid <= 0. out_data and out_sel hold their last values.
- No transfer and out_ready=0: all output registers hold.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle while out_ready=1 and req!=0.
- Back-pressure: out_valid=1 with out_ready=0 gives in_ready=0 on all channels. out_data must stay stable until accepted.
- Fairness: with every channel continuously requesting, grants rotate 0,1,...,NCH-1,0,...; no channel waits more than NCH-1 transfers.
- Simultaneous output pop and input push in one cycle: new data is loaded and out_valid stays 1 (no bubble).
- chan_en change: takes effect in the same cycle for arbitration. A word already in the output register is unaffected.
- Reset asserted mid-stream: the pending output word is discarded and the pointer returns to NCH-1.
- last_grant changes only on a transfer; idle cycles do not advance it.

Optional Feature:
- Macro: RR_ARB_MUX_PKT_LOCK_EN.
- With the macro defined:
  - Adds port in_last, input, NCH bits, marking the final word of a packet per channel.
  - Adds output register out_last, 1 bit, loaded alongside out_data; reset value 0.
  - On a transfer with in_last[k]=0 the arbiter locks to k: the next grant goes only to k, even if other channels request. Lock holds while chan_en[k]=1; chan_en[k]=0 does not break the lock.
  - The lock is released by a transfer with in_last[k]=1, or by reset.
  - last_grant updates only on the releasing transfer.
- Without the macro: in_last and out_last do not exist, and every transfer is arbitrated independently.

Test Plan:
- Reset: reset=1 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0. First grant after release goes to channel 0.
- Rotation: NCH=8, all in_valid=1, chan_en=8'hFF, in_data[k]=32'h1000_0000+k, out_ready=1 -> out_sel sequence 0,1,...,7,0 on consecutive cycles, out_data matching, no bubbles.
- Wrap and skip: after a transfer from channel 6, assert only in_valid[1] and in_valid[5] -> next grant 1, then 5.
- Back-pressure: out_valid=1 with out_data=32'hDEAD_BEEF, out_ready=0 for 5 cycles -> out_data stable, in_ready=0 throughout. Then out_ready=1 for 1 cycle -> pending word popped and a new word loaded in the same cycle.
- Masking: chan_en=8'b1111_1011, all channels valid -> channel 2 is never granted; rotation is 0,1,3,4,...
- Packet lock (macro defined): channel 3 sends 4 words with in_last=0,0,0,1 while channel 0 requests -> out_sel=3 for 4 consecutive words, then channel 0 is granted; out_last=1 only on the 4th word.
